// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and encodings for the MEM-stage data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } dmem_state_t;

    localparam logic [1:0] REWR_NOP = 2'b00;
    localparam logic [1:0] REWR_RD  = 2'b01;
    localparam logic [1:0] REWR_WR  = 2'b10;

    localparam logic [2:0] WHB_B  = 3'b000;
    localparam logic [2:0] WHB_H  = 3'b001;
    localparam logic [2:0] WHB_W  = 3'b010;
    localparam logic [2:0] WHB_BU = 3'b100;
    localparam logic [2:0] WHB_HU = 3'b101;

    function automatic logic whb_legal(input logic [2:0] whb);
        logic ok;
        case (whb)
            WHB_B, WHB_H, WHB_W, WHB_BU, WHB_HU: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - request/response bus between the MEM stage and the data-memory responder
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  MemReWr;
    logic [2:0]  MemWHB;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  RdAddr;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_RdAddr;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, MemReWr, MemWHB, addr, wdata, RdAddr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_RdAddr, rsp_err, busy
    );

    modport slave (
        input  req_valid, MemReWr, MemWHB, addr, wdata, RdAddr,
        output req_ready, rsp_valid, rsp_rdata, rsp_RdAddr, rsp_err, busy
    );
endinterface

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - load lane select and sign/zero extension
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  MemWHB,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = mem_rdata[7:0];
        case (addr_lo)
            2'd1:    lane_b = mem_rdata[15:8];
            2'd2:    lane_b = mem_rdata[23:16];
            2'd3:    lane_b = mem_rdata[31:24];
            default: lane_b = mem_rdata[7:0];
        endcase
        lane_h = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (MemWHB)
            WHB_B:   result = {{24{lane_b[7]}}, lane_b};
            WHB_BU:  result = {24'b0, lane_b};
            WHB_H:   result = {{16{lane_h[15]}}, lane_h};
            WHB_HU:  result = {16'b0, lane_h};
            default: result = mem_rdata;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage load/store responder driving a synchronous byte-enabled SRAM
// Build option: DMEM_MISALIGN_TRAP_EN turns misaligned H/W accesses into error responses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    dmem_if.slave             bus,
    output logic              mem_cs,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] LAST_WAIT = 3'(READ_LAT - 1);

    dmem_state_t state, state_nx;
    logic [2:0]  cnt;
    logic        ld_q, err_q;
    logic [1:0]  lo_q;
    logic [2:0]  whb_q;

    logic        is_rd, is_wr, legal, req_err, start;
    logic [1:0]  addr_lo;
    logic [3:0]  we_nx;
    logic [31:0] wdata_nx;
    logic [31:0] load_fmt;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        misal;
`endif

    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];

    always_comb begin
        is_rd = (bus.MemReWr == REWR_RD);
        is_wr = (bus.MemReWr == REWR_WR);
        legal = whb_legal(bus.MemWHB);
`ifdef DMEM_MISALIGN_TRAP_EN
        misal = 1'b0;
        case (bus.MemWHB)
            WHB_H, WHB_HU: misal = bus.addr[0];
            WHB_W:         misal = |bus.addr[1:0];
            default:       misal = 1'b0;
        endcase
        req_err = !legal || misal;
`else
        req_err = !legal;
`endif
        // Offending low bits are cleared; with trapping on, such requests never reach the SRAM.
        addr_lo = bus.addr[1:0];
        case (bus.MemWHB)
            WHB_H, WHB_HU: addr_lo = {bus.addr[1], 1'b0};
            WHB_W:         addr_lo = 2'b00;
            default:       addr_lo = bus.addr[1:0];
        endcase

        we_nx    = 4'b0000;
        wdata_nx = bus.wdata;
        case (bus.MemWHB)
            WHB_B, WHB_BU: begin
                we_nx    = 4'b0001 << addr_lo;
                wdata_nx = {4{bus.wdata[7:0]}};
            end
            WHB_H, WHB_HU: begin
                we_nx    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_nx = {2{bus.wdata[15:0]}};
            end
            WHB_W:   we_nx = 4'b1111;
            default: we_nx = 4'b0000;
        endcase

        start = (state == ST_IDLE) && bus.req_valid && (is_rd || is_wr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    // Errors take the ACCESS slot with the SRAM deselected so stores and errors both respond at T+2.
    always_comb begin
        state_nx      = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (start) state_nx = ST_ACCESS;
            end
            ST_ACCESS: state_nx = (ld_q && !err_q) ? ST_WAIT : ST_RESP;
            ST_WAIT:   if (cnt == LAST_WAIT) state_nx = ST_RESP;
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                state_nx      = ST_IDLE;
            end
            default:   state_nx = ST_IDLE;
        endcase
        bus.busy = !bus.req_ready;
    end

    dmem_load_align u_align (
        .mem_rdata (mem_rdata),
        .addr_lo   (lo_q),
        .MemWHB    (whb_q),
        .result    (load_fmt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt            <= 3'd0;
            ld_q           <= 1'b0;
            err_q          <= 1'b0;
            lo_q           <= 2'b00;
            whb_q          <= 3'b000;
            mem_cs         <= 1'b0;
            mem_we         <= 4'b0000;
            mem_addr       <= '0;
            mem_wdata      <= 32'd0;
            bus.rsp_rdata  <= 32'd0;
            bus.rsp_RdAddr <= 5'd0;
            bus.rsp_err    <= 1'b0;
        end else begin
            mem_cs <= 1'b0;
            mem_we <= 4'b0000;
            if (start) begin
                ld_q           <= is_rd;
                err_q          <= req_err;
                lo_q           <= addr_lo;
                whb_q          <= bus.MemWHB;
                mem_cs         <= !req_err;
                mem_we         <= (is_wr && !req_err) ? we_nx : 4'b0000;
                mem_addr       <= bus.addr[ADDR_W+1:2];
                mem_wdata      <= wdata_nx;
                bus.rsp_rdata  <= 32'd0;
                bus.rsp_RdAddr <= bus.RdAddr;
                bus.rsp_err    <= req_err;
            end
            if (state == ST_ACCESS)
                cnt <= 3'd0;
            else if (state == ST_WAIT)
                cnt <= cnt + 3'd1;
            if (state == ST_WAIT && cnt == LAST_WAIT)
                bus.rsp_rdata <= load_fmt;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder with READ_LAT=3
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int RL = 3;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_if bus();
    logic          mem_cs;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    dmem_responder #(.ADDR_W(AW), .READ_LAT(RL)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // SRAM model: data read at the select edge appears RL cycles after the select cycle.
    logic [31:0] sram [256];
    logic [31:0] rd_pipe [RL];
    always @(posedge clk) begin
        if (mem_cs)
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) sram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        rd_pipe[0] <= mem_cs ? sram[mem_addr[7:0]] : 32'hBAD0_BAD0;
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RL-1];

    int n_cmp = 0;
    int n_err = 0;

    int          cs_n, cs_k, rsp_n, rsp_k, busy_n;
    logic [3:0]  we_o;
    logic [31:0] ma_o, wd_o, rdata_o;
    logic        err_o, rdy_o;
    logic [4:0]  tag_o;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request in cycle T and records what happens over cycles T+1..T+8.
    task automatic run_req(input logic [1:0] rw, input logic [2:0] whb, input logic [31:0] a,
                           input logic [31:0] wd, input logic [4:0] rd);
        @(negedge clk);
        rdy_o         = bus.req_ready;
        bus.req_valid = 1'b1;
        bus.MemReWr   = rw;
        bus.MemWHB    = whb;
        bus.addr      = a;
        bus.wdata     = wd;
        bus.RdAddr    = rd;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        cs_n = 0; cs_k = 0; rsp_n = 0; rsp_k = 0; busy_n = 0;
        we_o = 4'h0; ma_o = 32'd0; wd_o = 32'd0; rdata_o = 32'd0; err_o = 1'b0; tag_o = 5'd0;
        for (int k = 1; k <= 8; k++) begin
            if (mem_cs) begin
                cs_n++; cs_k = k; we_o = mem_we; ma_o = 32'(mem_addr); wd_o = mem_wdata;
            end
            if (bus.rsp_valid) begin
                rsp_n++; rsp_k = k; rdata_o = bus.rsp_rdata; err_o = bus.rsp_err; tag_o = bus.rsp_RdAddr;
            end
            if (bus.busy) busy_n++;
            if (k < 8) @(negedge clk);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.MemReWr   = REWR_NOP;
        bus.MemWHB    = WHB_W;
        bus.addr      = 32'd0;
        bus.wdata     = 32'd0;
        bus.RdAddr    = 5'd0;

        #12;
        check("rst_ready",  32'(bus.req_ready), 32'd1);
        check("rst_busy",   32'(bus.busy),      32'd0);
        check("rst_cs",     32'(mem_cs),        32'd0);
        check("rst_we",     32'(mem_we),        32'd0);
        check("rst_rspv",   32'(bus.rsp_valid), 32'd0);
        check("rst_rdata",  bus.rsp_rdata,      32'd0);
        @(negedge clk);
        rst = 1'b1;

        // preload words 1 and 3
        run_req(REWR_WR, WHB_W, 32'h04, 32'h1122_3344, 5'd1);
        check("sw4_ready",  32'(rdy_o),  32'd1);
        check("sw4_csn",    cs_n,        32'd1);
        check("sw4_csk",    cs_k,        32'd1);
        check("sw4_we",     32'(we_o),   32'hF);
        check("sw4_addr",   ma_o,        32'd1);
        check("sw4_wdata",  wd_o,        32'h1122_3344);
        check("sw4_rspn",   rsp_n,       32'd1);
        check("sw4_rspk",   rsp_k,       32'd2);
        check("sw4_err",    32'(err_o),  32'd0);
        check("sw4_rdata",  rdata_o,     32'd0);
        check("sw4_tag",    32'(tag_o),  32'd1);
        check("sw4_busy",   busy_n,      32'd2);
        run_req(REWR_WR, WHB_W, 32'h0C, 32'hCAFE_0000, 5'd2);
        check("swc_addr",   ma_o,        32'd3);

        run_req(REWR_WR, WHB_W, 32'h08, 32'hDEAD_BEEF, 5'd5);
        check("sw8_we",     32'(we_o),   32'hF);
        check("sw8_addr",   ma_o,        32'd2);
        check("sw8_wdata",  wd_o,        32'hDEAD_BEEF);
        check("sw8_rspk",   rsp_k,       32'd2);
        check("sw8_tag",    32'(tag_o),  32'd5);

        run_req(REWR_RD, WHB_W, 32'h08, 32'h0, 5'd7);
        check("lw8_csn",    cs_n,        32'd1);
        check("lw8_csk",    cs_k,        32'd1);
        check("lw8_we",     32'(we_o),   32'h0);
        check("lw8_addr",   ma_o,        32'd2);
        check("lw8_rspn",   rsp_n,       32'd1);
        check("lw8_rspk",   rsp_k,       32'd5);
        check("lw8_rdata",  rdata_o,     32'hDEAD_BEEF);
        check("lw8_tag",    32'(tag_o),  32'd7);
        check("lw8_err",    32'(err_o),  32'd0);
        check("lw8_busy",   busy_n,      32'd5);

        run_req(REWR_WR, WHB_B, 32'h0D, 32'h1234_56A5, 5'd0);
        check("sb_we",      32'(we_o),   32'h2);
        check("sb_wdata",   wd_o,        32'hA5A5_A5A5);
        check("sb_addr",    ma_o,        32'd3);
        run_req(REWR_RD, WHB_B, 32'h0D, 32'h0, 5'd9);
        check("lb_rdata",   rdata_o,     32'hFFFF_FFA5);
        check("lb_tag",     32'(tag_o),  32'd9);
        run_req(REWR_RD, WHB_BU, 32'h0D, 32'h0, 5'd10);
        check("lbu_rdata",  rdata_o,     32'h0000_00A5);

        run_req(REWR_WR, WHB_H, 32'h12, 32'h0000_8001, 5'd0);
        check("sh_we",      32'(we_o),   32'hC);
        check("sh_wdata",   wd_o,        32'h8001_8001);
        check("sh_addr",    ma_o,        32'd4);
        run_req(REWR_RD, WHB_H, 32'h12, 32'h0, 5'd11);
        check("lh_rdata",   rdata_o,     32'hFFFF_8001);
        run_req(REWR_RD, WHB_HU, 32'h12, 32'h0, 5'd11);
        check("lhu_rdata",  rdata_o,     32'h0000_8001);

        run_req(REWR_RD, WHB_W, 32'h06, 32'h0, 5'd3);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("lw6_csn",    cs_n,        32'd0);
        check("lw6_rspk",   rsp_k,       32'd2);
        check("lw6_err",    32'(err_o),  32'd1);
        check("lw6_rdata",  rdata_o,     32'd0);
`else
        check("lw6_csn",    cs_n,        32'd1);
        check("lw6_addr",   ma_o,        32'd1);
        check("lw6_rspk",   rsp_k,       32'd5);
        check("lw6_err",    32'(err_o),  32'd0);
        check("lw6_rdata",  rdata_o,     32'h1122_3344);
`endif
        run_req(REWR_RD, WHB_H, 32'h0F, 32'h0, 5'd4);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("lhf_csn",    cs_n,        32'd0);
        check("lhf_err",    32'(err_o),  32'd1);
        check("lhf_rdata",  rdata_o,     32'd0);
`else
        check("lhf_addr",   ma_o,        32'd3);
        check("lhf_err",    32'(err_o),  32'd0);
        check("lhf_rdata",  rdata_o,     32'hFFFF_CAFE);
`endif
        run_req(REWR_WR, WHB_H, 32'h11, 32'h0000_BEEF, 5'd6);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("sh11_csn",   cs_n,        32'd0);
        check("sh11_err",   32'(err_o),  32'd1);
`else
        check("sh11_we",    32'(we_o),   32'h3);
        check("sh11_addr",  ma_o,        32'd4);
        check("sh11_wdata", wd_o,        32'hBEEF_BEEF);
        check("sh11_err",   32'(err_o),  32'd0);
`endif

        run_req(REWR_RD, 3'b011, 32'h00, 32'h0, 5'd8);
        check("ill_csn",    cs_n,        32'd0);
        check("ill_rspk",   rsp_k,       32'd2);
        check("ill_err",    32'(err_o),  32'd1);
        check("ill_rdata",  rdata_o,     32'd0);
        check("ill_tag",    32'(tag_o),  32'd8);
        check("ill_busy",   busy_n,      32'd2);
        run_req(REWR_WR, 3'b110, 32'h10, 32'hFFFF_FFFF, 5'd8);
        check("ill2_csn",   cs_n,        32'd0);
        check("ill2_err",   32'(err_o),  32'd1);

        run_req(REWR_NOP, WHB_W, 32'h08, 32'h0, 5'd13);
        check("nop_rspn",   rsp_n,       32'd0);
        check("nop_csn",    cs_n,        32'd0);
        check("nop_busy",   busy_n,      32'd0);
        run_req(2'b11, WHB_W, 32'h08, 32'h0, 5'd13);
        check("nop3_rspn",  rsp_n,       32'd0);
        check("nop3_ready", 32'(bus.req_ready), 32'd1);

        // reset in the middle of a load, at T+3
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.MemReWr   = REWR_RD;
        bus.MemWHB    = WHB_W;
        bus.addr      = 32'h08;
        bus.wdata     = 32'hFFFF_FFFF;
        bus.RdAddr    = 5'd21;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mr_ready",   32'(bus.req_ready),  32'd1);
        check("mr_busy",    32'(bus.busy),       32'd0);
        check("mr_cs",      32'(mem_cs),         32'd0);
        check("mr_we",      32'(mem_we),         32'd0);
        check("mr_addr",    32'(mem_addr),       32'd0);
        check("mr_wdata",   mem_wdata,           32'd0);
        check("mr_rspv",    32'(bus.rsp_valid),  32'd0);
        check("mr_rdata",   bus.rsp_rdata,       32'd0);
        check("mr_tag",     32'(bus.rsp_RdAddr), 32'd0);
        check("mr_err",     32'(bus.rsp_err),    32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        rsp_n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) rsp_n++;
        end
        check("mr_norsp",   rsp_n,               32'd0);

        run_req(REWR_RD, WHB_W, 32'h08, 32'h0, 5'd12);
        check("post_ready", 32'(rdy_o),  32'd1);
        check("post_rspk",  rsp_k,       32'd5);
        check("post_rdata", rdata_o,     32'hDEAD_BEEF);
        check("post_tag",   32'(tag_o),  32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
